// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if
// Bundles the producer handshake, the synchronized read pointer and the
// write-side status flags of the async FIFO write controller.
// master: the producer / surrounding FIFO logic; slave: the controller.
interface fifo_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   localparam int PW = ADDR_WIDTH + 1;

   logic                  w_inc;
   logic [PW-1:0]         rptr_sync;
   logic                  ovf_clr;
   logic                  w_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [PW-1:0]         wptr_gray;
   logic                  full;
   logic                  almost_full;
   logic                  overflow;

   modport master (
      output w_inc, rptr_sync, ovf_clr,
      input  w_en, w_addr, wptr_gray, full, almost_full, overflow
   );

   modport slave (
      input  w_inc, rptr_sync, ovf_clr,
      output w_en, w_addr, wptr_gray, full, almost_full, overflow
   );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
// Write-side pointer and flag controller of an async FIFO. Owns the binary
// and Gray write pointers, drives the memory write strobe/address, publishes
// the registered Gray pointer to the read-domain synchronizer and derives
// full / almost-full / sticky overflow from the synchronized read pointer.
// Optional feature macro: FIFO_WR_ALMOST_FULL_EN. When undefined the level
// subtractor and Gray-to-binary decode are not built and almost_full is 0.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int AF_MARGIN  = 2
) (
   input  logic         CLK,
   input  logic         RST,
   fifo_wr_ctrl_if.slave bus
);
   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Full when the writer is exactly one lap ahead: Gray pointers then
   // differ only in their two most significant bits.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

   logic [PW-1:0] w_bin_q;
   logic [PW-1:0] w_bin_d;
   logic [PW-1:0] w_gray_q;
   logic [PW-1:0] w_gray_d;
   logic          full_q;
   logic          full_d;
   logic          ovf_q;
   logic          ovf_d;
   logic          accept;

   // Next-state pointers and flags, all evaluated from same-edge inputs.
   always_comb begin
      accept   = bus.w_inc & ~full_q;
      w_bin_d  = w_bin_q + PW'(accept);
      w_gray_d = w_bin_d ^ (w_bin_d >> 1);
      full_d   = (w_gray_d == (bus.rptr_sync ^ FULL_MASK));
      ovf_d    = ovf_q;
      if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (bus.w_inc & full_q) begin
         ovf_d = 1'b1;
      end
   end

   // Pointer and status registers; reset returns everything to empty.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         w_bin_q  <= '0;
         w_gray_q <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         w_bin_q  <= w_bin_d;
         w_gray_q <= w_gray_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.w_en      = accept;
   assign bus.w_addr    = w_bin_q[ADDR_WIDTH-1:0];
   assign bus.wptr_gray = w_gray_q;
   assign bus.full      = full_q;
   assign bus.overflow  = ovf_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
   logic [PW-1:0] r_bin;
   logic [PW-1:0] level_d;
   logic [PW:0]   free_d;
   logic          af_q;
   logic          af_d;

   // Decode the read pointer to binary and compare free space to the margin.
   always_comb begin
      r_bin = '0;
      for (int i = 0; i < PW; i++) begin
         r_bin[i] = ^(bus.rptr_sync >> i);
      end
      level_d = w_bin_d - r_bin;
      free_d  = (PW+1)'(DEPTH) - {1'b0, level_d};
      af_d    = (free_d <= (PW+1)'(AF_MARGIN)) | full_d;
   end

   // Registered almost-full flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         af_q <= 1'b0;
      end else begin
         af_q <= af_d;
      end
   end

   assign bus.almost_full = af_q;
`else
   assign bus.almost_full = 1'b0;
`endif

   // The synchronized read pointer must move by at most one Gray step.
   a_rptr_one_bit: assert property (@(posedge CLK) disable iff (!RST)
      $countones(bus.rptr_sync ^ $past(bus.rptr_sync)) <= 1);

   // Almost-full margin must leave room between empty and full.
   a_margin_range: assert property (@(posedge CLK)
      (AF_MARGIN >= 1) && (AF_MARGIN < DEPTH));

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl
// Directed scenarios plus a randomized run, each checked against a
// write/read counting model of the FIFO occupancy.
module tb_fifo_wr_ctrl;
   localparam int AW    = 3;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 8;
   localparam int AFM   = 2;
`ifdef FIFO_WR_ALMOST_FULL_EN
   localparam bit AF_ON = 1'b1;
`else
   localparam bit AF_ON = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b0;

   fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus();

   fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   // Free-running write clock.
   always #5 CLK = ~CLK;

   int vectors     = 0;
   int miscompares = 0;

   // Model: total writes and reads modulo two laps, plus flags.
   int m_wr;
   int m_rd;
   bit m_full;
   bit m_af;
   bit m_ovf;

   logic          obs_wen;
   logic [AW-1:0] obs_waddr;
   logic          exp_wen;
   logic [AW-1:0] exp_waddr;

   function automatic logic [PW-1:0] gray(input int b);
      logic [PW-1:0] v;
      v = PW'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      m_wr   = 0;
      m_rd   = 0;
      m_full = 1'b0;
      m_af   = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic reset_dut();
      RST           = 1'b0;
      bus.w_inc     = 1'b0;
      bus.ovf_clr   = 1'b0;
      bus.rptr_sync = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
   endtask

   // Called at a negedge: drive inputs, capture combinational outputs,
   // take one active edge, update the model, return at the next negedge.
   task automatic step(input logic w, input int rd, input logic clr);
      int  level;
      bit  acc;
      bus.w_inc     = w;
      bus.ovf_clr   = clr;
      m_rd          = rd % 16;
      bus.rptr_sync = gray(m_rd);
      #1;
      obs_wen   = bus.w_en;
      obs_waddr = bus.w_addr;
      exp_wen   = w && !m_full;
      exp_waddr = AW'(m_wr % DEPTH);
      @(posedge CLK);
      acc    = w && !m_full;
      m_ovf  = (w && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_wr   = (m_wr + int'(acc)) % 16;
      level  = (m_wr - m_rd + 16) % 16;
      m_full = (level == DEPTH);
      m_af   = AF_ON && (level >= DEPTH - AFM);
      @(negedge CLK);
      bus.w_inc   = 1'b0;
      bus.ovf_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      vectors++;
      if ({bus.w_en, bus.wptr_gray, bus.full, bus.almost_full, bus.overflow} !== 8'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b expected 00000000",
                  {bus.w_en, bus.wptr_gray, bus.full, bus.almost_full, bus.overflow});
      end
      vectors++;
      if (bus.w_addr !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_waddr: got %0d expected 0", bus.w_addr);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, m_rd, 1'b0);
         vectors++;
         if (obs_waddr !== AW'(i) || obs_wen !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fill_write %0d: got addr %0d en %b expected addr %0d en 1",
                     i, obs_waddr, obs_wen, i);
         end
         vectors++;
         if ({bus.full, bus.almost_full} !== {(i == DEPTH - 1), (AF_ON && i >= DEPTH - AFM - 1)}) begin
            miscompares++;
            $display("[TB] FAIL fill_flags %0d: got full %b af %b expected full %b af %b",
                     i, bus.full, bus.almost_full, (i == DEPTH - 1), (AF_ON && i >= DEPTH - AFM - 1));
         end
      end
      vectors++;
      if (bus.wptr_gray !== 4'b1100) begin
         miscompares++;
         $display("[TB] FAIL fill_gray: got %b expected 1100", bus.wptr_gray);
      end
   endtask

   task automatic test_overflow();
      step(1'b1, m_rd, 1'b0);
      vectors++;
      if (obs_wen !== 1'b0 || obs_waddr !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL ovf_drop: got en %b addr %0d expected en 0 addr 0", obs_wen, obs_waddr);
      end
      vectors++;
      if ({bus.wptr_gray, bus.full, bus.overflow} !== 6'b1100_1_1) begin
         miscompares++;
         $display("[TB] FAIL ovf_set: got gray %b full %b ovf %b expected 1100 1 1",
                  bus.wptr_gray, bus.full, bus.overflow);
      end
      step(1'b0, m_rd, 1'b1);
      vectors++;
      if ({bus.full, bus.overflow} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL ovf_clear: got full %b ovf %b expected 1 0", bus.full, bus.overflow);
      end
   endtask

   task automatic test_read_release();
      step(1'b0, 1, 1'b0);
      vectors++;
      if (bus.full !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL release_full: got %b expected 0", bus.full);
      end
      step(1'b1, 1, 1'b0);
      vectors++;
      if (obs_wen !== 1'b1 || obs_waddr !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL release_write: got en %b addr %0d expected en 1 addr 0", obs_wen, obs_waddr);
      end
      vectors++;
      if ({bus.full, bus.wptr_gray} !== 5'b1_1101) begin
         miscompares++;
         $display("[TB] FAIL refill: got full %b gray %b expected 1 1101", bus.full, bus.wptr_gray);
      end
   endtask

   task automatic test_wrap();
      logic [PW-1:0] want;
      reset_dut();
      for (int k = 0; k < 16; k++) begin
         step(1'b1, m_rd, 1'b0);
         want = (k == 14) ? 4'b1000 : (k == 15) ? 4'b0000 : gray(k + 1);
         vectors++;
         if ({bus.wptr_gray, bus.full} !== {want, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_write %0d: got gray %b full %b expected %b 0",
                     k, bus.wptr_gray, bus.full, want);
         end
         step(1'b0, m_rd + 1, 1'b0);
         vectors++;
         if (bus.full !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_read %0d: got full %b expected 0", k, bus.full);
         end
      end
      vectors++;
      if (bus.w_addr !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL wrap_addr: got %0d expected 0", bus.w_addr);
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      for (int k = 0; k < 5; k++) begin
         step(1'b1, m_rd, 1'b0);
      end
      bus.w_inc = 1'b1;
      #2;
      RST       = 1'b0;
      bus.w_inc = 1'b0;
      #1;
      vectors++;
      if ({bus.w_en, bus.w_addr, bus.wptr_gray, bus.full, bus.almost_full, bus.overflow} !== 11'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got %b expected all zero",
                  {bus.w_en, bus.w_addr, bus.wptr_gray, bus.full, bus.almost_full, bus.overflow});
      end
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      step(1'b1, 0, 1'b0);
      vectors++;
      if (obs_wen !== 1'b1 || obs_waddr !== 3'd0 || bus.wptr_gray !== 4'b0001) begin
         miscompares++;
         $display("[TB] FAIL post_reset_write: got en %b addr %0d gray %b expected 1 0 0001",
                  obs_wen, obs_waddr, bus.wptr_gray);
      end
   endtask

   task automatic test_ovf_race();
      reset_dut();
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b1, m_rd, 1'b0);
      end
      step(1'b1, m_rd, 1'b1);
      vectors++;
      if (bus.overflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ovf_race: got %b expected 1", bus.overflow);
      end
      step(1'b0, m_rd, 1'b1);
      vectors++;
      if (bus.overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ovf_race_clear: got %b expected 0", bus.overflow);
      end
   endtask

   task automatic test_random();
      int  level;
      int  rd;
      reset_dut();
      for (int n = 0; n < 500; n++) begin
         level = (m_wr - m_rd + 16) % 16;
         rd    = m_rd;
         if (level > 0 && $urandom_range(0, 2) == 0) begin
            rd = m_rd + 1;
         end
         step(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 7) == 0));
         vectors++;
         if ({obs_wen, obs_waddr} !== {exp_wen, exp_waddr}) begin
            miscompares++;
            $display("[TB] FAIL rand_write %0d: got en %b addr %0d expected en %b addr %0d",
                     n, obs_wen, obs_waddr, exp_wen, exp_waddr);
         end
         vectors++;
         if ({bus.wptr_gray, bus.full, bus.almost_full, bus.overflow} !== {gray(m_wr), m_full, m_af, m_ovf}) begin
            miscompares++;
            $display("[TB] FAIL rand_state %0d: got gray %b f %b af %b ovf %b expected %b %b %b %b",
                     n, bus.wptr_gray, bus.full, bus.almost_full, bus.overflow,
                     gray(m_wr), m_full, m_af, m_ovf);
         end
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      bus.w_inc     = 1'b0;
      bus.ovf_clr   = 1'b0;
      bus.rptr_sync = '0;
      model_reset();
      @(negedge CLK);
      test_reset();
      test_fill();
      test_overflow();
      test_read_release();
      test_wrap();
      test_async_reset();
      test_ovf_race();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
